int_pin_conditioner: RTL and testbench
======================================

INT_PIN_CONDITIONER -- requirements
Module: int_pin_conditioner

Interface
REQ-001 SHALL have parameter NUM_OF_PINS, default 2, number of external interrupt pins (range 1..8).
REQ-002 SHALL have parameter FILTER_CYCLES, default 4, consecutive stable cycles needed to accept a filtered transition (range 1..255).
REQ-003 SHALL have port clk, input, 1, sole clock.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pins_in, input, NUM_OF_PINS, raw asynchronous external interrupt pins.
REQ-006 SHALL have port active_low_mask, input, NUM_OF_PINS, 1 = pin asserted when low.
REQ-007 SHALL have port filter_enable, input, NUM_OF_PINS, 1 = glitch filter active for that pin.
REQ-008 SHALL have port flag_clear, input, NUM_OF_PINS, one-cycle strobe clearing the matching int_flags bit.
REQ-009 SHALL have port int_pins, output, NUM_OF_PINS, registered, synchronized, filtered, active-high interrupt levels driving the interrupt controller's int_pins.
REQ-010 SHALL have port int_flags, output, NUM_OF_PINS, sticky rising-edge capture flags (TCON IEx-style status).

Function
REQ-011 SHALL apply polarity per pin as pins_in XOR active_low_mask ahead of synchronization, so that 1 always means asserted.
REQ-012 SHALL pass each polarity-corrected pin through a two-flop synchronizer (s1, s2) before any other use.
REQ-013 SHALL, with filter_enable=0, register s2 into int_pins, giving exactly 3 clk edges from a pins_in change (setup met) to int_pins.
REQ-014 SHALL, with filter_enable=1, keep a per-pin counter (width clog2(FILTER_CYCLES+1)) that increments each cycle s2 differs from int_pins and clears to 0 on any cycle s2 equals int_pins.
REQ-015 SHALL toggle int_pins and clear the counter on the edge where the counter equals FILTER_CYCLES-1 while s2 still differs, giving latency 2+FILTER_CYCLES edges.
REQ-016 SHALL reject any pulse on s2 shorter than FILTER_CYCLES cycles, with int_pins unchanged and no flag set.
REQ-017 SHALL clear the counter in the same cycle filter_enable is deasserted.
REQ-018 SHALL, when filter_enable changes mid-count, apply no partial count; counting restarts from 0.
REQ-019 SHALL hold a registered copy int_pins_d1 and set int_flags[i] on the cycle after int_pins[i] rises (int_pins & ~int_pins_d1).
REQ-020 SHALL clear int_flags[i] on the edge following a cycle with flag_clear[i]=1.
REQ-021 SHALL give set priority when a flag set and flag_clear coincide, leaving the flag at 1.
REQ-022 SHALL treat a change of active_low_mask as an input transition: it passes through sync and filter and can set a flag; this behaviour is intended and not suppressed.
REQ-023 SHALL keep pins fully independent, with no cross-pin interaction.

Reset
REQ-024 SHALL, on reset_n low, asynchronously clear s1, s2, counters, int_pins, int_pins_d1 and int_flags to 0.
REQ-025 SHALL, when reset_n deasserts while a pin is held asserted, see it as a fresh transition: int_pins rises after normal latency and int_flags sets.
REQ-026 SHALL abort filtering in progress on reset asserted mid-count, with no output change after release until a full new qualification.

Structure
REQ-027 SHALL take INT_COND_MAX_PINS=8 and INT_COND_DEFAULT_FILTER=4 from shared package int_cond_pkg.
REQ-028 SHALL be built from one per-pin sub-module, int_pin_filter (synchronizer, counter, output register, edge flag), instantiated NUM_OF_PINS times by generate.
REQ-029 SHALL contain no combinational path from any input to any output.

Verification
REQ-030 SHALL verify bypass latency: filter_enable=0, pins_in[0] 0->1 at edge 10 -> int_pins[0]=1 after edge 12, int_flags[0]=1 after edge 13.
REQ-031 SHALL verify glitch rejection: FILTER_CYCLES=4, filter on, s2 high for 3 cycles -> int_pins stays 0, int_flags stays 0; high for 4 cycles -> int_pins rises at edge 2+4 from the input change.
REQ-032 SHALL verify active-low: active_low_mask[1]=1, pins_in[1] held 1 out of reset -> int_pins[1]=0; pins_in[1] driven 0 -> int_pins[1]=1 and int_flags[1]=1.
REQ-033 SHALL verify set/clear collision: flag_clear[0] pulsed on the same cycle as the int_pins[0] rising-edge detect -> int_flags[0]=1; a lone flag_clear pulse later -> 0 next edge.
REQ-034 SHALL verify reset mid-operation: reset_n low during count 2 of 4 with pin high, released with pin high -> int_pins=0 during reset, rises FILTER_CYCLES+2 edges after release, flag sets.
REQ-035 SHALL verify independence: pins 0 and 1 toggled with different filter settings -> each output matches its own model, with no cross-coupling.

Source files
------------

// File: rtl/int_cond_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// int_cond_pkg : shared limits and sizing helper for the interrupt pin
//                conditioner.
// Revision     : 1.0
// ----------------------------------------------------------------------------
package int_cond_pkg;

  localparam int INT_COND_MAX_PINS       = 8;
  localparam int INT_COND_DEFAULT_FILTER = 4;

  // Counter must reach FILTER_CYCLES-1, so FILTER_CYCLES+1 states always fit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage : int_cond_pkg
`default_nettype wire

// File: rtl/int_pin_filter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// int_pin_filter : per-pin polarity, 2-flop sync, glitch filter, edge flag.
// Revision       : 1.0
// ----------------------------------------------------------------------------
module int_pin_filter
  import int_cond_pkg::*;
#(
  parameter int FILTER_CYCLES = INT_COND_DEFAULT_FILTER
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  input  logic i_active_low,
  input  logic i_filter_en,
  input  logic i_flag_clear,
  output logic o_int,
  output logic o_flag
);

  localparam int                 c_cnt_w    = cnt_width(FILTER_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic               r_s1;
  logic               r_s2;
  logic               r_int;
  logic               r_int_d1;
  logic               r_flag;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_pol;
  logic               w_differ;
  logic               w_rise;

  assign w_pol    = i_pin ^ i_active_low;
  assign w_differ = r_s2 ^ r_int;
  assign w_rise   = r_int & ~r_int_d1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= w_pol;
      r_s2 <= r_s1;
    end
  end

  // Bypass drops any partial count so re-enabling always starts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_int <= 1'b0;
    end else if (!i_filter_en) begin
      r_cnt <= '0;
      r_int <= r_s2;
    end else if (!w_differ) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt <= '0;
      r_int <= r_s2;
    end else begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  // A new rising edge wins over a coincident clear strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_int_d1 <= 1'b0;
      r_flag   <= 1'b0;
    end else begin
      r_int_d1 <= r_int;
      if (w_rise) begin
        r_flag <= 1'b1;
      end else if (i_flag_clear) begin
        r_flag <= 1'b0;
      end
    end
  end

  assign o_int  = r_int;
  assign o_flag = r_flag;

endmodule : int_pin_filter
`default_nettype wire

// File: rtl/int_pin_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// int_pin_conditioner : conditions raw external interrupt pins into clean,
//                       synchronous active-high levels plus sticky edge flags.
// Revision            : 1.0
// ----------------------------------------------------------------------------
module int_pin_conditioner
  import int_cond_pkg::*;
#(
  parameter int NUM_OF_PINS   = 2,
  parameter int FILTER_CYCLES = INT_COND_DEFAULT_FILTER
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_OF_PINS-1:0] pins_in,
  input  logic [NUM_OF_PINS-1:0] active_low_mask,
  input  logic [NUM_OF_PINS-1:0] filter_enable,
  input  logic [NUM_OF_PINS-1:0] flag_clear,
  output logic [NUM_OF_PINS-1:0] int_pins,
  output logic [NUM_OF_PINS-1:0] int_flags
);

  for (genvar gi = 0; gi < NUM_OF_PINS; gi++) begin : g_pin
    int_pin_filter #(
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_pin        (pins_in[gi]),
      .i_active_low (active_low_mask[gi]),
      .i_filter_en  (filter_enable[gi]),
      .i_flag_clear (flag_clear[gi]),
      .o_int        (int_pins[gi]),
      .o_flag       (int_flags[gi])
    );
  end

endmodule : int_pin_conditioner
`default_nettype wire

// File: tb/tb_int_pin_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_int_pin_conditioner : self-checking bench, pulse table plus corner cases.
// Revision               : 1.0
// ----------------------------------------------------------------------------
module tb_int_pin_conditioner;

  localparam int NP = 2;
  localparam int FC = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NP-1:0] pins_in;
  logic [NP-1:0] active_low_mask;
  logic [NP-1:0] filter_enable;
  logic [NP-1:0] flag_clear;
  logic [NP-1:0] int_pins;
  logic [NP-1:0] int_flags;

  int_pin_conditioner #(
    .NUM_OF_PINS   (NP),
    .FILTER_CYCLES (FC)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pins_in         (pins_in),
    .active_low_mask (active_low_mask),
    .filter_enable   (filter_enable),
    .flag_clear      (flag_clear),
    .int_pins        (int_pins),
    .int_flags       (int_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    int    pin;
    bit    is_flag;
    logic  val;
    string name;
  } exp_t;

  typedef struct {
    int    pin;
    bit    fen;
    bit    al;
    int    len;
    bit    rise;
    int    lat;
    string name;
  } vec_t;

  exp_t sb[$];
  vec_t vt[7];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_at(input int dly, input int pin, input bit is_flag,
                           input logic val, input string name);
    exp_t e;
    e.cyc     = cyc + dly;
    e.pin     = pin;
    e.is_flag = is_flag;
    e.val     = val;
    e.name    = name;
    sb.push_back(e);
  endtask

  task automatic check_due();
    exp_t keep[$];
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc)
        check(sb[i].name, sb[i].is_flag ? int_flags[sb[i].pin] : int_pins[sb[i].pin], sb[i].val);
      else
        keep.push_back(sb[i]);
    end
    sb = keep;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      check_due();
    end
  endtask

  task automatic clear_flag(input int pin, input string name);
    flag_clear[pin] = 1'b1;
    expect_at(1, pin, 1'b1, 1'b0, name);
    tick(1);
    flag_clear[pin] = 1'b0;
    tick(2);
  endtask

  // Idle level keeps the polarity-corrected pin at 0; the pulse asserts it.
  task automatic run_vec(input vec_t v);
    int other;
    other = 1 - v.pin;
    filter_enable[v.pin]   = v.fen;
    active_low_mask[v.pin] = v.al;
    pins_in[v.pin]         = v.al;
    tick(12);
    pins_in[v.pin] = ~v.al;
    if (v.rise) begin
      expect_at(v.lat - 1, v.pin, 1'b0, 1'b0, {v.name, "_int_early"});
      expect_at(v.lat,     v.pin, 1'b0, 1'b1, {v.name, "_int_rise"});
      expect_at(v.lat,     v.pin, 1'b1, 1'b0, {v.name, "_flag_early"});
      expect_at(v.lat + 1, v.pin, 1'b1, 1'b1, {v.name, "_flag_set"});
    end else begin
      expect_at(2 + FC, v.pin, 1'b0, 1'b0, {v.name, "_int_rejected"});
      expect_at(3 + FC, v.pin, 1'b0, 1'b0, {v.name, "_int_rejected2"});
      expect_at(4 + FC, v.pin, 1'b1, 1'b0, {v.name, "_flag_none"});
    end
    expect_at(v.lat, other, 1'b0, 1'b0, {v.name, "_other_int"});
    tick(v.len);
    pins_in[v.pin] = v.al;
    tick(14);
    clear_flag(v.pin, {v.name, "_flag_clr"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 1'b0, 1'b0, 1, 1'b1, 3,      "byp_p0_len1"};
    vt[1] = '{0, 1'b1, 1'b0, 3, 1'b0, 2 + FC, "flt_p0_len3"};
    vt[2] = '{0, 1'b1, 1'b0, 4, 1'b1, 2 + FC, "flt_p0_len4"};
    vt[3] = '{1, 1'b1, 1'b1, 2, 1'b0, 2 + FC, "flt_p1_al_len2"};
    vt[4] = '{1, 1'b0, 1'b1, 2, 1'b1, 3,      "byp_p1_al_len2"};
    vt[5] = '{1, 1'b1, 1'b1, 5, 1'b1, 2 + FC, "flt_p1_al_len5"};
    vt[6] = '{0, 1'b1, 1'b1, 1, 1'b0, 2 + FC, "flt_p0_al_len1"};

    // Reset with pin 1 active-low and held high (deasserted).
    pins_in         = 2'b10;
    active_low_mask = 2'b10;
    filter_enable   = 2'b00;
    flag_clear      = 2'b00;
    tick(3);
    check("reset_int", int_pins, 8'h0);
    check("reset_flag", int_flags, 8'h0);
    reset_n = 1'b1;
    tick(8);
    check("al_idle_int1", int_pins[1], 8'h0);
    check("al_idle_flags", int_flags, 8'h0);

    foreach (vt[i]) run_vec(vt[i]);

    // Clear strobe coincident with the rising-edge detect: set wins.
    filter_enable[0]   = 1'b0;
    active_low_mask[0] = 1'b0;
    pins_in[0]         = 1'b0;
    tick(6);
    pins_in[0] = 1'b1;
    tick(3);
    check("coll_int_rise", int_pins[0], 8'h1);
    check("coll_flag_pre", int_flags[0], 8'h0);
    flag_clear[0] = 1'b1;
    tick(1);
    check("coll_set_wins", int_flags[0], 8'h1);
    flag_clear[0] = 1'b0;
    tick(2);
    check("coll_flag_sticky", int_flags[0], 8'h1);
    flag_clear[0] = 1'b1;
    tick(1);
    check("coll_lone_clear", int_flags[0], 8'h0);
    flag_clear[0] = 1'b0;
    pins_in[0] = 1'b0;
    tick(6);

    // Filter dropped mid-count: bypass takes the pending level at once.
    filter_enable[0] = 1'b1;
    tick(4);
    pins_in[0] = 1'b1;
    tick(4);
    filter_enable[0] = 1'b0;
    expect_at(1, 0, 1'b0, 1'b1, "fen_drop_int");
    expect_at(2, 0, 1'b1, 1'b1, "fen_drop_flag");
    tick(1);
    filter_enable[0] = 1'b1;
    pins_in[0] = 1'b0;
    tick(12);
    check("fen_drop_fall", int_pins[0], 8'h0);
    clear_flag(0, "fen_drop_clr");

    // Reset asserted at count 2 of 4, released with the pin still high.
    pins_in[0] = 1'b1;
    tick(4);
    reset_n = 1'b0;
    #1;
    check("rst_mid_int", int_pins, 8'h0);
    check("rst_mid_flag", int_flags, 8'h0);
    tick(3);
    check("rst_hold_int", int_pins[0], 8'h0);
    reset_n = 1'b1;
    expect_at(FC + 1, 0, 1'b0, 1'b0, "rst_rel_int_early");
    expect_at(FC + 2, 0, 1'b0, 1'b1, "rst_rel_int_rise");
    expect_at(FC + 2, 0, 1'b1, 1'b0, "rst_rel_flag_early");
    expect_at(FC + 3, 0, 1'b1, 1'b1, "rst_rel_flag_set");
    tick(10);
    pins_in[0] = 1'b0;
    tick(10);
    clear_flag(0, "rst_rel_clr");

    // Mask change alone is a real transition.
    pins_in[0]         = 1'b0;
    filter_enable[0]   = 1'b0;
    active_low_mask[0] = 1'b1;
    expect_at(3, 0, 1'b0, 1'b1, "mask_int_rise");
    expect_at(4, 0, 1'b1, 1'b1, "mask_flag_set");
    tick(6);
    active_low_mask[0] = 1'b0;
    tick(6);
    clear_flag(0, "mask_clr");

    // Pins with different filter settings switched together.
    filter_enable      = 2'b10;
    active_low_mask[1] = 1'b0;
    pins_in            = 2'b00;
    tick(10);
    pins_in = 2'b11;
    expect_at(2, 0, 1'b0, 1'b0, "ind_p0_early");
    expect_at(3, 0, 1'b0, 1'b1, "ind_p0_rise");
    expect_at(3, 1, 1'b0, 1'b0, "ind_p1_hold3");
    expect_at(FC + 1, 1, 1'b0, 1'b0, "ind_p1_early");
    expect_at(FC + 2, 1, 1'b0, 1'b1, "ind_p1_rise");
    expect_at(4, 0, 1'b1, 1'b1, "ind_p0_flag");
    expect_at(4, 1, 1'b1, 1'b0, "ind_p1_flag_early");
    expect_at(FC + 3, 1, 1'b1, 1'b1, "ind_p1_flag");
    tick(10);
    pins_in = 2'b00;
    expect_at(3, 0, 1'b0, 1'b0, "ind_p0_fall");
    expect_at(3, 1, 1'b0, 1'b1, "ind_p1_glitch3");
    expect_at(FC + 4, 1, 1'b0, 1'b1, "ind_p1_glitch_rej");
    tick(2);
    pins_in[1] = 1'b1;
    tick(10);
    clear_flag(0, "ind_p0_clr");
    clear_flag(1, "ind_p1_clr");

    tick(2);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_int_pin_conditioner
`default_nettype wire
